// File: rtl/muldiv_unit_pkg.sv
// Shared opcode header plus types for the multiply/divide unit.
`ifndef MDU_HEAD
`define MDU_HEAD
`define MDU_MULT  2'b00
`define MDU_MULTU 2'b01
`define MDU_DIV   2'b10
`define MDU_DIVU  2'b11
`endif

package muldiv_unit_pkg;

   typedef enum logic {S_IDLE, S_RUN} mdu_state_e;

   // Operation captured at launch; the result depends on this copy only.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic        madd;
   } mdu_req_t;

   function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational datapath: next {hi,lo} for the latched op, plus divide-by-zero flag.
module muldiv_calc
   import muldiv_unit_pkg::*;
(
   input  mdu_req_t    req,
   input  logic [63:0] hilo,
   output logic [63:0] result,
   output logic        div0
);

   logic        is_signed;
   logic [63:0] ext_a, ext_b, prod;
   logic        neg_a, neg_b;
   logic [31:0] mag_a, mag_b, divisor, quo_u, rem_u, quo, rem;

   always_comb begin
      is_signed = (req.op == `MDU_MULT) || (req.op == `MDU_DIV);
      // Low 64 bits of the extended product are correct for both signednesses.
      ext_a = is_signed ? {{32{req.a[31]}}, req.a} : {32'b0, req.a};
      ext_b = is_signed ? {{32{req.b[31]}}, req.b} : {32'b0, req.b};
      prod  = ext_a * ext_b;

      neg_a   = is_signed & req.a[31];
      neg_b   = is_signed & req.b[31];
      mag_a   = neg_if(neg_a, req.a);
      mag_b   = neg_if(neg_b, req.b);
      div0    = req.op[1] && (req.b == 32'd0);
      divisor = div0 ? 32'd1 : mag_b;
      quo_u   = mag_a / divisor;
      rem_u   = mag_a % divisor;
      quo     = neg_if(neg_a ^ neg_b, quo_u);
      rem     = neg_if(neg_a, rem_u);

      if (req.op[1])
         result = {rem, quo};
      else if (req.madd)
         result = hilo + prod;
      else
         result = prod;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/div unit with HI/LO registers; FSM counts down then commits.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [1:0]  op,
   input  logic        madd,
   input  logic        start,
   input  logic        we,
   input  logic        hilo,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_e        state_q, state_n;
   logic [CNT_W-1:0]  count_q, count_n;
   mdu_req_t          req_q;
   logic              load, commit, hi_we, lo_we, div0;
   logic [63:0]       result;

   muldiv_calc u_calc (
      .req    (req_q),
      .hilo   ({hi, lo}),
      .result (result),
      .div0   (div0)
   );

   always_comb begin
      state_n = state_q;
      count_n = count_q;
      load    = 1'b0;
      commit  = 1'b0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A register move wins over a simultaneous launch.
            if (we) begin
               hi_we = hilo;
               lo_we = ~hilo;
            end else if (start) begin
               load    = 1'b1;
               state_n = S_RUN;
               count_n = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            end
         end
         S_RUN: begin
            if (count_q == '0) begin
               commit  = 1'b1;
               state_n = S_IDLE;
            end else begin
               count_n = count_q - CNT_W'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         req_q   <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         if (load)
            req_q <= '{a: d1, b: d2, op: op, madd: madd};
         if (commit) begin
            if (!div0)
               {hi, lo} <= result;
         end else begin
            if (hi_we) hi <= d1;
            if (lo_we) lo <= d1;
         end
      end
   end

   assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] d1, d2;
   logic [1:0]  op;
   logic        madd, start, we, hilo;
   logic        busy;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_fail = 0;

   muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .d1    (d1),
      .d2    (d2),
      .op    (op),
      .madd  (madd),
      .start (start),
      .we    (we),
      .hilo  (hilo),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Register move: drive for one edge, sample on the following negedge.
   task automatic mt(input logic to_hi, input logic [31:0] v);
      d1 = v; hilo = to_hi; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   // Launch an op, then count busy cycles (bounded) until it drops.
   task automatic run_op(input logic [1:0] o, input logic m, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
      d1 = a; d2 = b; op = o; madd = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      d1 = 32'hDEAD_BEEF; d2 = 32'h1234_5678;
      cyc = 0;
      while (busy && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   int cyc;

   initial begin
      reset = 1'b0; d1 = '0; d2 = '0; op = '0; madd = 0; start = 0; we = 0; hilo = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op(2'b00, 0, 32'hFFFF_FFFE, 32'd3, cyc);
      chk("mult_cyc", cyc, 32'd5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);

      run_op(2'b01, 0, 32'hFFFF_FFFE, 32'd3, cyc);
      chk("multu_hi", hi, 32'h0000_0002);
      chk("multu_lo", lo, 32'hFFFF_FFFA);

      run_op(2'b10, 0, 32'hFFFF_FFF9, 32'd2, cyc);
      chk("div_cyc", cyc, 32'd10);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      mt(1'b1, 32'h11);
      mt(1'b0, 32'h22);
      run_op(2'b11, 1, 32'd7, 32'd0, cyc);
      chk("div0_cyc", cyc, 32'd10);
      chk("div0_hi", hi, 32'h11);
      chk("div0_lo", lo, 32'h22);

      mt(1'b1, 32'h0);
      mt(1'b0, 32'hFFFF_FFFF);
      run_op(2'b01, 1, 32'd1, 32'd1, cyc);
      chk("maddu_hi", hi, 32'h1);
      chk("maddu_lo", lo, 32'h0);

      d1 = 32'hAB; hilo = 1'b1; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      chk("mthi_hi", hi, 32'hAB);
      chk("mthi_busy", {31'b0, busy}, 32'd0);

      run_op(2'b10, 0, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      chk("divovf_lo", lo, 32'h8000_0000);
      chk("divovf_hi", hi, 32'h0);

      run_op(2'b11, 0, 32'hFFFF_FFFF, 32'h10, cyc);
      chk("divu_lo", lo, 32'h0FFF_FFFF);
      chk("divu_hi", hi, 32'hF);

      // Signed MADD of -1: {F,0FFFFFFF} - 1
      run_op(2'b00, 1, 32'hFFFF_FFFF, 32'd1, cyc);
      chk("madd_hi", hi, 32'hF);
      chk("madd_lo", lo, 32'h0FFF_FFFE);

      // start/we while busy and operand changes must not matter
      d1 = 32'd3; d2 = 32'd4; op = 2'b00; madd = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      d1 = 32'd100; d2 = 32'd7; op = 2'b10; start = 1'b1; we = 1'b1; hilo = 1'b1;
      @(negedge clk);
      start = 1'b0; we = 1'b0;
      chk("busy_mid", {31'b0, busy}, 32'd1);
      cyc = 0;
      while (busy && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
      chk("ign_cyc", cyc, 32'd3);
      chk("ign_hi", hi, 32'h0);
      chk("ign_lo", lo, 32'd12);

      // we and start together in IDLE: write only
      d1 = 32'h55; hilo = 1'b0; we = 1'b1; start = 1'b1; op = 2'b00;
      @(negedge clk);
      we = 1'b0; start = 1'b0;
      chk("we_start_busy", {31'b0, busy}, 32'd0);
      chk("we_start_lo", lo, 32'h55);
      @(negedge clk);
      chk("we_start_busy2", {31'b0, busy}, 32'd0);

      // Reset mid-op discards the operation
      d1 = 32'd3; d2 = 32'd4; op = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_hi", hi, 32'h0);
      chk("mid_rst_lo", lo, 32'h0);
      repeat (8) @(negedge clk);
      chk("late_commit_lo", lo, 32'h0);
      chk("late_busy", {31'b0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
